// File: rtl/riscv_pkg.sv
// RV32I opcode constants, immediate format enum and instruction field helpers
// shared by the decode stage and its register file.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic is_base_opcode(input logic [6:0] opc);
        logic ok;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // R-type, FENCE and SYSTEM carry no immediate the datapath uses.
    function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
        imm_fmt_e f;
        case (opc)
            OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_NONE;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] v;
        case (fmt)
            FMT_I:   v = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   v = {instr[31:12], 12'b0};
            FMT_J:   v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: v = 32'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port;
// x0 is hardwired to zero and optional same-cycle write-to-read forwarding.
module regfile_2r1w #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int BYPASS   = 1,
    parameter int RF_RESET = 1,
    localparam int RA      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA-1:0]   rd_addr1,
    input  logic [RA-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    input  logic            wr_en,
    input  logic [RA-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] mem [NREG];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // With RF_RESET=0 the array keeps its contents across rst; writes pause while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (RF_RESET != 0) begin
                for (int i = 0; i < NREG; i++) mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = mem[rd_addr1];
        if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr1)) rd_data1 = wr_data;
        if (rd_addr1 == '0) rd_data1 = '0;
    end

    always_comb begin
        rd_data2 = mem[rd_addr2];
        if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr2)) rd_data2 = wr_data;
        if (rd_addr2 == '0) rd_data2 = '0;
    end

endmodule

// File: rtl/decode_stage_hs.sv
// RISC-V decode stage: operand read with WB bypass, immediate/target generation,
// load-use interlock and flush, registered into a valid/ready ID/EX stage.
module decode_stage_hs
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int BYPASS   = 1,
    parameter int RF_RESET = 1,
    localparam int RA      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [31:0]     id_instr_i,
    input  logic            wb_we_i,
    input  logic [RA-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs1_o,
    output logic [XLEN-1:0] ex_rs2_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [XLEN-1:0] ex_target_o,
    output logic [31:0]     ex_instr_o,
    output logic            ex_illegal_o,
    output logic            hazard_o
);

    logic [6:0]      opc;
    logic [6:0]      ex_opc;
    imm_fmt_e        fmt;
    logic [RA-1:0]   rs1_addr;
    logic [RA-1:0]   rs2_addr;
    logic [RA-1:0]   ex_rd_addr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
    logic            use_rs1;
    logic            use_rs2;
    logic            advance;

    assign opc        = opcode_of(id_instr_i);
    assign fmt        = fmt_of(opc);
    assign rs1_addr   = RA'(rs1_of(id_instr_i));
    assign rs2_addr   = RA'(rs2_of(id_instr_i));
    assign ex_opc     = opcode_of(ex_instr_o);
    assign ex_rd_addr = RA'(rd_of(ex_instr_o));

    assign illegal = !is_base_opcode(opc);
    assign imm     = XLEN'($signed(imm_of(id_instr_i, fmt)));
    assign target  = id_pc_i + imm;

    regfile_2r1w #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .BYPASS   (BYPASS),
        .RF_RESET (RF_RESET)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rs1_addr),
        .rd_addr2 (rs2_addr),
        .rd_data1 (rs1_val),
        .rd_data2 (rs2_val),
        .wr_en    (wb_we_i),
        .wr_addr  (wb_rd_i),
        .wr_data  (wb_data_i)
    );

    // Only sources the format really reads may stall on a pending load.
    assign use_rs1 = !((opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL));
    assign use_rs2 = (opc == OP_OP) || (opc == OP_STORE) || (opc == OP_BRANCH);

    assign hazard_o = ex_valid_o && (ex_opc == OP_LOAD) && (ex_rd_addr != '0) &&
                      ((use_rs1 && (rs1_addr == ex_rd_addr)) ||
                       (use_rs2 && (rs2_addr == ex_rd_addr)));

    assign advance    = ex_ready_i || !ex_valid_o;
    assign id_ready_o = flush_i || (advance && !hazard_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= '0;
            ex_rs1_o     <= '0;
            ex_rs2_o     <= '0;
            ex_imm_o     <= '0;
            ex_target_o  <= '0;
            ex_instr_o   <= '0;
            ex_illegal_o <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (advance) begin
            if (hazard_o) begin
                ex_valid_o <= 1'b0;
            end else begin
                ex_valid_o   <= id_valid_i;
                ex_pc_o      <= id_pc_i;
                ex_rs1_o     <= rs1_val;
                ex_rs2_o     <= rs2_val;
                ex_imm_o     <= imm;
                ex_target_o  <= target;
                ex_instr_o   <= id_instr_i;
                ex_illegal_o <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Self-checking bench for decode_stage_hs: immediate table through a scoreboard,
// plus hand sequences for bypass, load-use, backpressure, flush and reset.
module tb_decode_stage_hs;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;

    logic        id_ready, ex_valid, ex_illegal, hazard;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_target, ex_instr;

    logic        id_ready_b, ex_valid_b, ex_illegal_b, hazard_b;
    logic [31:0] ex_pc_b, ex_rs1_b, ex_rs2_b, ex_imm_b, ex_target_b, ex_instr_b;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage_hs dut (
        .clk (clk), .rst (rst),
        .id_valid_i (id_valid), .id_ready_o (id_ready), .id_pc_i (id_pc), .id_instr_i (id_instr),
        .wb_we_i (wb_we), .wb_rd_i (wb_rd), .wb_data_i (wb_data), .flush_i (flush),
        .ex_valid_o (ex_valid), .ex_ready_i (ex_ready), .ex_pc_o (ex_pc), .ex_rs1_o (ex_rs1),
        .ex_rs2_o (ex_rs2), .ex_imm_o (ex_imm), .ex_target_o (ex_target), .ex_instr_o (ex_instr),
        .ex_illegal_o (ex_illegal), .hazard_o (hazard)
    );

    decode_stage_hs #(.BYPASS(0), .RF_RESET(0)) dut_b (
        .clk (clk), .rst (rst),
        .id_valid_i (id_valid), .id_ready_o (id_ready_b), .id_pc_i (id_pc), .id_instr_i (id_instr),
        .wb_we_i (wb_we), .wb_rd_i (wb_rd), .wb_data_i (wb_data), .flush_i (flush),
        .ex_valid_o (ex_valid_b), .ex_ready_i (ex_ready), .ex_pc_o (ex_pc_b), .ex_rs1_o (ex_rs1_b),
        .ex_rs2_o (ex_rs2_b), .ex_imm_o (ex_imm_b), .ex_target_o (ex_target_b), .ex_instr_o (ex_instr_b),
        .ex_illegal_o (ex_illegal_b), .hazard_o (hazard_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] target;
        logic        illegal;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];
    vec_t e;

    localparam logic [31:0] I_ADD_X1_X5_X0 = 32'h000280B3;
    localparam logic [31:0] I_ADD_X1_X0_X0 = 32'h000000B3;
    localparam logic [31:0] I_LW_X3        = 32'h00012183;
    localparam logic [31:0] I_ADD_X4_X3_X1 = 32'h00118233;
    localparam logic [31:0] I_LUI_X4       = 32'h00018237;
    localparam logic [31:0] I_ADDI_X4_X1_3 = 32'h00308213;
    localparam logic [31:0] I_SW_X3        = 32'h0030A023;
    localparam logic [31:0] I_ADD_X1_X2_X3 = 32'h003100B3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 32'hFE000EE3, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0}; // beq -4
        vecs[1] = '{32'hFFFF_FFF0, 32'h0200006F, 32'h0000_0020, 32'h0000_0010, 1'b0}; // jal +0x20 wraps
        vecs[2] = '{32'h0000_0200, 32'h0000007F, 32'h0000_0000, 32'h0000_0200, 1'b1}; // opcode 0x7F
        vecs[3] = '{32'h0000_0010, 32'hFFF00093, 32'hFFFF_FFFF, 32'h0000_000F, 1'b0}; // addi -1
        vecs[4] = '{32'h0000_0040, 32'h0020A423, 32'h0000_0008, 32'h0000_0048, 1'b0}; // sw 8
        vecs[5] = '{32'h0000_0000, 32'h12345237, 32'h1234_5000, 32'h1234_5000, 1'b0}; // lui
        vecs[6] = '{32'h0000_1000, 32'hFFFFF297, 32'hFFFF_F000, 32'h0000_0000, 1'b0}; // auipc wraps
        vecs[7] = '{32'h0000_0020, 32'h003100B3, 32'h0000_0000, 32'h0000_0020, 1'b0}; // add R-type
        vecs[8] = '{32'h0000_0008, 32'hFF8080E7, 32'hFFFF_FFF8, 32'h0000_0000, 1'b0}; // jalr -8
        vecs[9] = '{32'h0000_0050, 32'h00000000, 32'h0000_0000, 32'h0000_0050, 1'b1}; // opcode 0

        rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_instr = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
        #12;
        rst = 1'b0;
        #1;
        check("reset ex_valid", 32'(ex_valid), 32'd0);
        check("reset id_ready", 32'(id_ready), 32'd1);
        check("reset ex_pc", ex_pc, 32'd0);
        check("reset ex_instr", ex_instr, 32'd0);

        // Known x5 value in both instances, including the one without RF reset.
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'd0;
        step();
        wb_we = 1'b0;

        id_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            id_pc = vecs[i].pc;
            id_instr = vecs[i].instr;
            sb.push_back(vecs[i]);
            step();
            e = sb.pop_front();
            check($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 32'd1);
            check($sformatf("vec%0d ex_pc", i), ex_pc, e.pc);
            check($sformatf("vec%0d ex_instr", i), ex_instr, e.instr);
            check($sformatf("vec%0d ex_imm", i), ex_imm, e.imm);
            check($sformatf("vec%0d ex_target", i), ex_target, e.target);
            check($sformatf("vec%0d ex_illegal", i), 32'(ex_illegal), 32'(e.illegal));
        end
        id_valid = 1'b0;
        step();
        check("drain ex_valid", 32'(ex_valid), 32'd0);

        // Bypass vs. no bypass
        id_valid = 1'b1; id_pc = 32'h100; id_instr = I_ADD_X1_X5_X0;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        wb_we = 1'b0;
        check("bypass rs1", ex_rs1, 32'hDEADBEEF);
        check("no-bypass rs1", ex_rs1_b, 32'h0);
        step();
        check("after write rs1 nobyp", ex_rs1_b, 32'hDEADBEEF);

        // x0 stays zero
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd5; id_instr = I_ADD_X1_X0_X0;
        step();
        wb_we = 1'b0;
        check("x0 bypass rs1", ex_rs1, 32'd0);
        step();
        check("x0 read rs1", ex_rs1, 32'd0);
        check("x0 read rs1 nobyp", ex_rs1_b, 32'd0);

        // Load-use on rs1 and rs2 of an add
        id_instr = I_LW_X3;
        step();
        check("lw in ex", ex_instr, I_LW_X3);
        id_instr = I_ADD_X4_X3_X1;
        #1;
        check("load-use hazard", 32'(hazard), 32'd1);
        check("load-use id_ready", 32'(id_ready), 32'd0);
        step();
        check("bubble ex_valid", 32'(ex_valid), 32'd0);
        check("bubble hazard", 32'(hazard), 32'd0);
        check("bubble id_ready", 32'(id_ready), 32'd1);
        step();
        check("add after bubble valid", 32'(ex_valid), 32'd1);
        check("add after bubble instr", ex_instr, I_ADD_X4_X3_X1);

        // LUI and an I-type whose imm field aliases rd: no stall
        id_instr = I_LW_X3;
        step();
        id_instr = I_LUI_X4;
        #1;
        check("lui no hazard", 32'(hazard), 32'd0);
        step();
        check("lui enters ex", ex_instr, I_LUI_X4);
        id_instr = I_LW_X3;
        step();
        id_instr = I_ADDI_X4_X1_3;
        #1;
        check("addi no hazard", 32'(hazard), 32'd0);
        step();
        check("addi enters ex", ex_instr, I_ADDI_X4_X1_3);

        // Store using x3 as rs2 stalls; flush during the stall
        id_instr = I_LW_X3;
        step();
        id_instr = I_SW_X3;
        #1;
        check("store rs2 hazard", 32'(hazard), 32'd1);
        flush = 1'b1;
        #1;
        check("flush id_ready", 32'(id_ready), 32'd1);
        step();
        flush = 1'b0;
        check("flush ex_valid", 32'(ex_valid), 32'd0);
        id_pc = 32'h300; id_instr = I_ADDI_X4_X1_3;
        step();
        check("post-flush valid", 32'(ex_valid), 32'd1);
        check("post-flush instr", ex_instr, I_ADDI_X4_X1_3);

        // Backpressure for three cycles
        ex_ready = 1'b0; id_pc = 32'h304; id_instr = I_ADD_X1_X2_X3;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d id_ready", k), 32'(id_ready), 32'd0);
            check($sformatf("bp%0d ex_instr", k), ex_instr, I_ADDI_X4_X1_3);
            check($sformatf("bp%0d ex_pc", k), ex_pc, 32'h300);
            step();
        end
        ex_ready = 1'b1;
        #1;
        check("bp release id_ready", 32'(id_ready), 32'd1);
        step();
        check("bp release instr", ex_instr, I_ADD_X1_X2_X3);
        check("bp release pc", ex_pc, 32'h304);

        // Async reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        check("async rst ex_valid", 32'(ex_valid), 32'd0);
        check("async rst ex_pc", ex_pc, 32'd0);
        check("async rst ex_instr", ex_instr, 32'd0);
        check("async rst ex_rs1", ex_rs1, 32'd0);
        check("async rst ex_target", ex_target, 32'd0);
        #1;
        rst = 1'b0;
        id_pc = 32'h0; id_instr = I_ADD_X1_X5_X0;
        step();
        check("rf cleared x5", ex_rs1, 32'd0);
        check("rf kept x5", ex_rs1_b, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
